// File: rtl/cache_line_ctrl_pkg.sv
// rtl/cache_line_ctrl_pkg.sv - shared constants, state encoding and address slice helpers for cache_line_ctrl
package cache_line_ctrl_pkg;

    localparam int LINE_W  = 128;
    localparam int TAG_W   = 20;
    localparam int INDEX_W = 8;
    localparam int BURST   = 4;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOOKUP    = 3'd1,
        ST_FILL_REQ  = 3'd2,
        ST_FILL_DATA = 3'd3,
        ST_WRITE     = 3'd4
    } state_t;

    // Line index lives directly above the 16-byte offset.
    function automatic logic [INDEX_W-1:0] index_of(input logic [31:0] addr);
        return addr[INDEX_W+3:4];
    endfunction

    // Tag is everything above the index.
    function automatic logic [TAG_W-1:0] tag_of(input logic [31:0] addr);
        return addr[31:32-TAG_W];
    endfunction

endpackage

// File: rtl/cache_fill_buffer.sv
// rtl/cache_fill_buffer.sv - beat counter and 128-bit line assembly register for burst line fills
module cache_fill_buffer
    import cache_line_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              beat_valid,
    input  logic [31:0]       beat_data,
    output logic [LINE_W-1:0] line,
    output logic              last_beat
);

    logic [1:0] beat_cnt;

    assign last_beat = beat_valid && (beat_cnt == 2'(BURST - 1));

    // Beat n lands in word n of the line; start rewinds the counter for a new fill.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            beat_cnt <= '0;
            line     <= '0;
        end else if (start) begin
            beat_cnt <= '0;
        end else if (beat_valid) begin
            line[{beat_cnt, 5'd0} +: 32] <= beat_data;
            beat_cnt                     <= beat_cnt + 2'd1;
        end
    end

endmodule

// File: rtl/cache_line_ctrl.sv
// rtl/cache_line_ctrl.sv - direct-mapped read cache controller with burst line fill (optional CACHE_STATS_EN counters)
module cache_line_ctrl
    import cache_line_ctrl_pkg::*;
#(
    parameter int LINES   = 256,
    parameter int INDEX_W = 8,
    parameter int BURST   = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_do,
    input  logic [31:0]  req_address,
    output logic         req_done,
    output logic [127:0] req_data,
    output logic [31:0]  ram_address,
    output logic         ram_read_do,
    input  logic [147:0] ram_q,
    output logic         ram_write_do,
    output logic [127:0] ram_data,
    output logic [31:0]  mem_address,
    output logic         mem_read,
    output logic [2:0]   mem_burstcount,
    input  logic         mem_waitrequest,
    input  logic [31:0]  mem_readdata,
    input  logic         mem_readdatavalid,
    input  logic         invalidate_do,
    input  logic         snoop_do,
    input  logic [31:0]  snoop_address
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]  stat_hits,
    output logic [31:0]  stat_misses
`endif
);

    state_t              state;
    state_t              state_next;
    logic [31:0]         addr_q;
    logic [LINES-1:0]    valid_q;
    logic [LINES-1:0]    valid_d;
    logic                no_alloc_q;
    logic [INDEX_W-1:0]  idx;
    logic [INDEX_W-1:0]  snoop_idx;
    logic                lookup_hit;
    logic                snoop_match;
    logic                fill_start;
    logic                beat_valid;
    logic                last_beat;
    logic [LINE_W-1:0]   fill_line;
    logic                unused_snoop_bits;

    assign idx               = index_of(addr_q);
    assign snoop_idx         = index_of(snoop_address);
    assign snoop_match       = snoop_do && (snoop_idx == idx);
    assign lookup_hit        = (state == ST_LOOKUP) && valid_q[idx] &&
                               (ram_q[147:128] == tag_of(addr_q));
    assign fill_start        = (state == ST_FILL_REQ) && !mem_waitrequest;
    assign beat_valid        = (state == ST_FILL_DATA) && mem_readdatavalid;
    assign mem_burstcount    = 3'(BURST);
    assign unused_snoop_bits = ^{snoop_address[31:12], snoop_address[3:0]};

    cache_fill_buffer u_fill (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (fill_start),
        .beat_valid (beat_valid),
        .beat_data  (mem_readdata),
        .line       (fill_line),
        .last_beat  (last_beat)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and per-state strobes; the RAM is read in the accepting cycle.
    always_comb begin
        state_next   = state;
        req_done     = 1'b0;
        req_data     = '0;
        ram_address  = addr_q;
        ram_read_do  = 1'b0;
        ram_write_do = 1'b0;
        ram_data     = '0;
        mem_address  = '0;
        mem_read     = 1'b0;
        case (state)
            ST_IDLE: begin
                ram_address = req_address;
                if (req_do) begin
                    ram_read_do = 1'b1;
                    state_next  = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                if (lookup_hit) begin
                    req_done   = 1'b1;
                    req_data   = ram_q[127:0];
                    state_next = ST_IDLE;
                end else begin
                    state_next = ST_FILL_REQ;
                end
            end
            ST_FILL_REQ: begin
                mem_read    = 1'b1;
                mem_address = {addr_q[31:4], 4'b0000};
                if (!mem_waitrequest) begin
                    state_next = ST_FILL_DATA;
                end
            end
            ST_FILL_DATA: begin
                if (last_beat) begin
                    state_next = ST_WRITE;
                end
            end
            ST_WRITE: begin
                ram_write_do = 1'b1;
                ram_data     = fill_line;
                req_done     = 1'b1;
                req_data     = fill_line;
                state_next   = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Request address latch and no-allocate flag for fills overtaken by a clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q     <= '0;
            no_alloc_q <= 1'b0;
        end else if (state == ST_IDLE) begin
            if (req_do) begin
                addr_q     <= req_address;
                no_alloc_q <= 1'b0;
            end
        end else if (invalidate_do || snoop_match) begin
            no_alloc_q <= 1'b1;
        end
    end

    // Valid-bit update: set on a completed fill, clears applied afterwards so they win.
    always_comb begin
        valid_d = valid_q;
        if ((state == ST_WRITE) && !no_alloc_q) begin
            valid_d[idx] = 1'b1;
        end
        if (snoop_do) begin
            valid_d[snoop_idx] = 1'b0;
        end
        if (invalidate_do) begin
            valid_d = '0;
        end
    end

    // Valid-bit register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

`ifdef CACHE_STATS_EN
    // Hit/miss counters per LOOKUP outcome, zeroed by invalidate-all.
    always_ff @(posedge clk) begin
        if (!rst_n || invalidate_do) begin
            stat_hits   <= '0;
            stat_misses <= '0;
        end else if (state == ST_LOOKUP) begin
            if (lookup_hit) begin
                stat_hits <= stat_hits + 32'd1;
            end else begin
                stat_misses <= stat_misses + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cache_line_ctrl.sv
// tb/tb_cache_line_ctrl.sv - directed self-checking bench for cache_line_ctrl
module tb_cache_line_ctrl;

    logic         clk;
    logic         rst_n;
    logic         req_do;
    logic [31:0]  req_address;
    logic         req_done;
    logic [127:0] req_data;
    logic [31:0]  ram_address;
    logic         ram_read_do;
    logic [147:0] ram_q;
    logic         ram_write_do;
    logic [127:0] ram_data;
    logic [31:0]  mem_address;
    logic         mem_read;
    logic [2:0]   mem_burstcount;
    logic         mem_waitrequest;
    logic [31:0]  mem_readdata;
    logic         mem_readdatavalid;
    logic         invalidate_do;
    logic         snoop_do;
    logic [31:0]  snoop_address;
`ifdef CACHE_STATS_EN
    logic [31:0]  stat_hits;
    logic [31:0]  stat_misses;
`endif

    logic [147:0] ram_mem [256];
    int           passed;
    int           total;

    localparam logic [127:0] L1 = 128'h44444444_33333333_22222222_11111111;
    localparam logic [127:0] L2 = 128'hDDDD0004_CCCC0003_BBBB0002_AAAA0001;
    localparam logic [127:0] L3 = 128'h0F0F0F0F_F0F0F0F0_12345678_9ABCDEF0;
    localparam logic [127:0] L4 = 128'hFFFFFFFF_00000000_80000001_7FFFFFFE;
    localparam logic [127:0] L5 = 128'h01020304_05060708_090A0B0C_0D0E0F10;

    cache_line_ctrl dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .req_do            (req_do),
        .req_address       (req_address),
        .req_done          (req_done),
        .req_data          (req_data),
        .ram_address       (ram_address),
        .ram_read_do       (ram_read_do),
        .ram_q             (ram_q),
        .ram_write_do      (ram_write_do),
        .ram_data          (ram_data),
        .mem_address       (mem_address),
        .mem_read          (mem_read),
        .mem_burstcount    (mem_burstcount),
        .mem_waitrequest   (mem_waitrequest),
        .mem_readdata      (mem_readdata),
        .mem_readdatavalid (mem_readdatavalid),
        .invalidate_do     (invalidate_do),
        .snoop_do          (snoop_do),
        .snoop_address     (snoop_address)
`ifdef CACHE_STATS_EN
        ,
        .stat_hits         (stat_hits),
        .stat_misses       (stat_misses)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External cache data RAM: registered read, tag stored with the line.
    always @(posedge clk) begin
        if (ram_write_do) ram_mem[ram_address[11:4]] <= {ram_address[31:12], ram_data};
        if (ram_read_do) ram_q <= ram_mem[ram_address[11:4]];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete request; miss path plays a 4-beat burst, optionally snooping at one beat.
    task automatic do_access(input string nm, input logic [31:0] addr, input bit exp_hit,
                             input logic [127:0] line, input int waits,
                             input int snoop_beat, input logic [31:0] snp_addr);
        logic [31:0] aligned;
        aligned = {addr[31:4], 4'b0000};
        req_do = 1'b1;
        req_address = addr;
        #1;
        total++;
        if ({ram_read_do, ram_address} !== {1'b1, addr}) begin
            $display("FAIL %s_accept: got rd=%b addr=%h expected rd=1 addr=%h", nm, ram_read_do, ram_address, addr);
        end else passed++;
        step();
        if (exp_hit) begin
            total++;
            if ({req_done, req_data, mem_read} !== {1'b1, line, 1'b0}) begin
                $display("FAIL %s_hit: got done=%b data=%h mem_read=%b expected done=1 data=%h mem_read=0", nm, req_done, req_data, mem_read, line);
            end else passed++;
            req_do = 1'b0;
            step();
            return;
        end
        total++;
        if (req_done !== 1'b0) begin
            $display("FAIL %s_lookup_miss: got done=%b expected 0", nm, req_done);
        end else passed++;
        step();
        mem_waitrequest = (waits > 0);
        total++;
        if ({mem_read, mem_address, mem_burstcount} !== {1'b1, aligned, 3'd4}) begin
            $display("FAIL %s_fill_req: got rd=%b addr=%h bc=%0d expected rd=1 addr=%h bc=4", nm, mem_read, mem_address, mem_burstcount, aligned);
        end else passed++;
        for (int i = 0; i < waits; i++) begin
            step();
            if (i == waits - 1) mem_waitrequest = 1'b0;
            total++;
            if ({mem_read, mem_address} !== {1'b1, aligned}) begin
                $display("FAIL %s_wait_stable: got rd=%b addr=%h expected rd=1 addr=%h", nm, mem_read, mem_address, aligned);
            end else passed++;
        end
        step();
        for (int b = 0; b < 4; b++) begin
            mem_readdatavalid = 1'b1;
            mem_readdata = line[32*b +: 32];
            if (b == snoop_beat) begin
                snoop_do = 1'b1;
                snoop_address = snp_addr;
            end
            step();
            snoop_do = 1'b0;
        end
        mem_readdatavalid = 1'b0;
        mem_readdata = 32'hDEAD_BEEF;
        #1;
        total++;
        if ({ram_write_do, ram_address, ram_data} !== {1'b1, addr, line}) begin
            $display("FAIL %s_write: got we=%b addr=%h data=%h expected we=1 addr=%h data=%h", nm, ram_write_do, ram_address, ram_data, addr, line);
        end else passed++;
        total++;
        if ({req_done, req_data, mem_read} !== {1'b1, line, 1'b0}) begin
            $display("FAIL %s_done: got done=%b data=%h mem_read=%b expected done=1 data=%h mem_read=0", nm, req_done, req_data, mem_read, line);
        end else passed++;
        req_do = 1'b0;
        step();
        total++;
        if ({req_done, ram_write_do} !== 2'b00) begin
            $display("FAIL %s_after: got done=%b we=%b expected 0 0", nm, req_done, ram_write_do);
        end else passed++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step();
        total++;
        if ({req_done, ram_read_do, ram_write_do, mem_read, mem_address, req_data, mem_burstcount} !==
            {4'b0000, 32'h0, 128'h0, 3'd4}) begin
            $display("FAIL reset_outputs: got done=%b rd=%b we=%b mrd=%b maddr=%h data=%h bc=%0d expected zeros bc=4",
                     req_done, ram_read_do, ram_write_do, mem_read, mem_address, req_data, mem_burstcount);
        end else passed++;
        rst_n = 1'b1;
        step();
        total++;
        if ({req_done, ram_read_do, mem_read} !== 3'b000) begin
            $display("FAIL reset_idle: got done=%b rd=%b mrd=%b expected 0 0 0", req_done, ram_read_do, mem_read);
        end else passed++;
    endtask

    task automatic test_cold_miss();
        do_access("cold_miss", 32'h0001_2340, 1'b0, L1, 0, -1, 32'h0);
    endtask

    task automatic test_hit();
        do_access("hit", 32'h0001_234C, 1'b1, L1, 0, -1, 32'h0);
    endtask

    task automatic test_tag_conflict();
        do_access("conflict_fill", 32'h0002_2340, 1'b0, L2, 0, -1, 32'h0);
        do_access("conflict_refill", 32'h0001_2340, 1'b0, L1, 0, -1, 32'h0);
        do_access("conflict_rehit", 32'h0001_2344, 1'b1, L1, 0, -1, 32'h0);
    endtask

    task automatic test_snoop_fill();
        do_access("snoop_fill", 32'h0002_2340, 1'b0, L2, 0, 1, 32'h0001_2348);
        do_access("snoop_remiss", 32'h0002_2340, 1'b0, L2, 0, -1, 32'h0);
    endtask

    task automatic test_waitrequest();
        do_access("wait_fill", 32'h0003_2340, 1'b0, L3, 5, 0, 32'h0000_0500);
        do_access("wait_hit", 32'h0003_2340, 1'b1, L3, 0, -1, 32'h0);
    endtask

    task automatic test_invalidate();
        do_access("inv_fill0", 32'h0000_0000, 1'b0, L4, 0, -1, 32'h0);
        do_access("inv_fillff", 32'h0000_0FF0, 1'b0, L5, 0, -1, 32'h0);
        do_access("inv_hit0", 32'h0000_0008, 1'b1, L4, 0, -1, 32'h0);
        do_access("inv_hitff", 32'h0000_0FFC, 1'b1, L5, 0, -1, 32'h0);
        invalidate_do = 1'b1;
        step();
        invalidate_do = 1'b0;
`ifdef CACHE_STATS_EN
        total++;
        if ({stat_hits, stat_misses} !== 64'h0) begin
            $display("FAIL inv_stats: got hits=%0d misses=%0d expected 0 0", stat_hits, stat_misses);
        end else passed++;
`endif
        do_access("inv_miss0", 32'h0000_0000, 1'b0, L4, 0, -1, 32'h0);
        do_access("inv_missff", 32'h0000_0FF0, 1'b0, L5, 0, -1, 32'h0);
`ifdef CACHE_STATS_EN
        total++;
        if ({stat_hits, stat_misses} !== {32'd0, 32'd2}) begin
            $display("FAIL post_inv_stats: got hits=%0d misses=%0d expected 0 2", stat_hits, stat_misses);
        end else passed++;
`endif
    endtask

    task automatic test_reset_mid_fill();
        req_do = 1'b1;
        req_address = 32'h0000_5670;
        step();
        step();
        step();
        for (int b = 0; b < 2; b++) begin
            mem_readdatavalid = 1'b1;
            mem_readdata = 32'hCAFE_0000 + 32'(b);
            step();
        end
        mem_readdatavalid = 1'b0;
        req_do = 1'b0;
        rst_n = 1'b0;
        step();
        total++;
        if ({mem_read, req_done, ram_write_do, ram_read_do} !== 4'b0000) begin
            $display("FAIL reset_mid_fill: got mrd=%b done=%b we=%b rd=%b expected 0 0 0 0", mem_read, req_done, ram_write_do, ram_read_do);
        end else passed++;
        rst_n = 1'b1;
        step();
        do_access("post_reset_miss", 32'h0000_5670, 1'b0, L3, 0, -1, 32'h0);
    endtask

    initial begin
        passed = 0;
        total = 0;
        for (int i = 0; i < 256; i++) ram_mem[i] = '0;
        ram_q = '0;
        req_do = 1'b0;
        req_address = '0;
        mem_waitrequest = 1'b0;
        mem_readdata = '0;
        mem_readdatavalid = 1'b0;
        invalidate_do = 1'b0;
        snoop_do = 1'b0;
        snoop_address = '0;
        rst_n = 1'b0;
        test_reset();
        test_cold_miss();
        test_hit();
        test_tag_conflict();
        test_snoop_fill();
        test_waitrequest();
        test_invalidate();
        test_reset_mid_fill();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
